// File: rtl/kyber_params_pkg.sv
// Shared Kyber parameters for the decryption/encryption reduce stages.
// Holds the ring size and modulus, the Barrett constants used to fold a
// 16-bit unreduced coefficient into [0, q), and the sequencing state enum.
package kyber_params_pkg;

    localparam int          KYBER_N       = 256;
    localparam logic [11:0] KYBER_Q       = 12'd3329;
    localparam int          DATA_WIDTH    = 12;
    localparam int          W_WIDTH       = 16;
    localparam logic [14:0] BARRETT_V     = 15'd20159;
    localparam int          BARRETT_SHIFT = 26;
    localparam logic [7:0]  ADDR_LAST     = 8'(KYBER_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/state_poly_sub_reduce_if.sv
// Bus bundle of the mp = (v - s^T u) mod q stage.
//   enable              start request
//   DecV_RData [11:0]   v[k] from the decompressed-v RAM
//   StU_RData  [15:0]   unreduced (s^T u)[k] from the INTT RAM
//   DecV_StU_RAd [7:0]  shared read address of both source RAMs
//   Reduce_DecMp_WEn/WAd/WData  write port into the Reduce_DecMp RAM
//   Function_done       one-cycle completion pulse
// master: the reduce stage. slave: RAMs and sequencer around it.
interface state_poly_sub_reduce_if;

    logic        enable;
    logic [11:0] DecV_RData;
    logic [15:0] StU_RData;
    logic [7:0]  DecV_StU_RAd;
    logic        Reduce_DecMp_WEn;
    logic [7:0]  Reduce_DecMp_WAd;
    logic [11:0] Reduce_DecMp_WData;
    logic        Function_done;

    modport master (
        input  enable, DecV_RData, StU_RData,
        output DecV_StU_RAd, Reduce_DecMp_WEn, Reduce_DecMp_WAd,
               Reduce_DecMp_WData, Function_done
    );

    modport slave (
        output enable, DecV_RData, StU_RData,
        input  DecV_StU_RAd, Reduce_DecMp_WEn, Reduce_DecMp_WAd,
               Reduce_DecMp_WData, Function_done
    );

endinterface

// File: rtl/barrett_reduce16.sv
// Two-register Barrett reduction of a 16-bit unsigned value modulo q.
//   clk, rst_n   clock, synchronous active-low reset
//   w_in  [15:0] unreduced input, captured every cycle
//   r_out [11:0] w mod q, two cycles after w_in
// First register holds w and p = w * 20159; second holds the folded result.
module barrett_reduce16
    import kyber_params_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] w_in,
    output logic [11:0] r_out
);

    logic [15:0] w_q, w_d;
    logic [31:0] p_q, p_d;
    logic [11:0] r_q, r_d;
    logic [5:0]  t;
    logic [15:0] tq;
    logic [15:0] r_raw;
    logic [15:0] r_fold;

    always_comb begin
        w_d    = w_in;
        p_d    = {16'd0, w_in} * {17'd0, BARRETT_V};
        // quotient estimate never exceeds 19, so r_raw lands in [0, 2q)
        t      = 6'(p_q >> BARRETT_SHIFT);
        tq     = {10'd0, t} * {4'd0, KYBER_Q};
        r_raw  = w_q - tq;
        r_fold = (r_raw >= {4'd0, KYBER_Q}) ? r_raw - {4'd0, KYBER_Q} : r_raw;
        r_d    = 12'(r_fold);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q <= '0;
            p_q <= '0;
            r_q <= '0;
        end else begin
            w_q <= w_d;
            p_q <= p_d;
            r_q <= r_d;
        end
    end

    assign r_out = r_q;

endmodule

// File: rtl/state_poly_sub_reduce.sv
// Decryption-side stage computing mp[k] = (v[k] - (s^T u)[k]) mod q for all
// 256 coefficients, one per cycle, into the Reduce_DecMp RAM.
//   clk, rst_n   clock, synchronous active-low reset
//   bus          state_poly_sub_reduce_if.master (RAM ports, enable, done)
//   cycle_count  [15:0] pass length counter, present only when
//                STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN is defined
//
// state | meaning
// IDLE  | strobes low, waiting for enable
// ISSUE | read addresses 0..255, one per cycle
// DRAIN | last coefficients travel through the pipeline
// DONE  | Function_done pulse, back to IDLE
module state_poly_sub_reduce
    import kyber_params_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    state_poly_sub_reduce_if.master bus
`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
    ,
    output logic [15:0]             cycle_count
`endif
);

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    // vld/ad chain: [0] RAM data cycle, [1] stage 1, [2] stage 2, [3] write
    logic [3:0]        vld_q, vld_d;
    logic [3:0][7:0]   ad_q, ad_d;
    logic [11:0]       v1_q, v1_d;
    logic [11:0]       v2_q, v2_d;
    logic [11:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [11:0]       r_red;
    logic signed [12:0] diff;
`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
    logic [15:0]       cnt_q, cnt_d;
`endif

    barrett_reduce16 u_barrett (
        .clk   (clk),
        .rst_n (rst_n),
        .w_in  (bus.StU_RData),
        .r_out (r_red)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (bus.enable) state_d = ISSUE;
            end
            ISSUE: begin
                if (addr_q == ADDR_LAST) state_d = DRAIN;
                else                     addr_d  = addr_q + 8'd1;
            end
            DRAIN: begin
                // only the final write is left once the first three slots are empty
                if (vld_q[2:0] == 3'b000) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        vld_d = {vld_q[2:0], state_q == ISSUE};
        ad_d  = {ad_q[2:0], addr_q};
        v1_d  = bus.DecV_RData;
        v2_d  = v1_q;

        diff    = $signed({1'b0, v2_q}) - $signed({1'b0, r_red});
        wdata_d = diff[12] ? 12'($unsigned(diff) + {1'b0, KYBER_Q})
                           : 12'($unsigned(diff));

`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (bus.enable) cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            vld_q   <= '0;
            ad_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            ad_q    <= ad_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.DecV_StU_RAd       = addr_q;
    assign bus.Reduce_DecMp_WEn   = vld_q[3];
    assign bus.Reduce_DecMp_WAd   = ad_q[3];
    assign bus.Reduce_DecMp_WData = wdata_q;
    assign bus.Function_done      = done_q;
`ifdef STATE_POLY_SUB_REDUCE_CYCLE_CNT_EN
    assign cycle_count            = cnt_q;
`endif

endmodule
